// File: rtl/acc_controller.sv
// Multicycle FSM controller for the 16-bit accumulator datapath.
// State advances on clk; all control lines are decoded from the current state, plus run (FETCH) and zero (JZ).
module acc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] inst,
    input  logic        zero,
    output logic        IRwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        pcwrite,
    output logic        accwrite,
    output logic        pcsrc,
    output logic        alusrc1,
    output logic        alusrc2,
    output logic        memtoacc,
    output logic        iord,
    output logic [2:0]  alucrtl,
    output logic [3:0]  state,
    output logic        instr_done
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMRD  = 4'd2,
        S_LDWB   = 4'd3,
        S_EXEC   = 4'd4,
        S_ALUWB  = 4'd5,
        S_STORE  = 4'd6,
        S_JUMP   = 4'd7,
        S_JZ     = 4'd8
    } state_t;

    localparam logic [2:0] OP_LDA = 3'd0, OP_STA = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
                           OP_AND = 3'd4, OP_NOT = 3'd5, OP_JMP = 3'd6, OP_JZ  = 3'd7;

    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                           ALU_NOT = 3'b011, ALU_PASS = 3'b100;

    state_t     cur;
    logic [2:0] opcode;
    logic       unused_addr;

    assign opcode      = inst[15:13];
    assign unused_addr = ^inst[12:0];
    assign state       = cur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= S_FETCH;
        end else begin
            case (cur)
                S_FETCH:  if (run) cur <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_STA:  cur <= S_STORE;
                        OP_NOT:  cur <= S_EXEC;
                        OP_JMP:  cur <= S_JUMP;
                        OP_JZ:   cur <= S_JZ;
                        default: cur <= S_MEMRD;
                    endcase
                end
                S_MEMRD:  cur <= (opcode == OP_LDA) ? S_LDWB : S_EXEC;
                S_EXEC:   cur <= S_ALUWB;
                default:  cur <= S_FETCH;
            endcase
        end
    end

    // Gating on reset makes every enable drop the instant reset asserts, even with run high in FETCH.
    always_comb begin
        IRwrite    = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        pcwrite    = 1'b0;
        accwrite   = 1'b0;
        pcsrc      = 1'b0;
        alusrc1    = 1'b0;
        alusrc2    = 1'b0;
        memtoacc   = 1'b0;
        iord       = 1'b0;
        alucrtl    = ALU_ADD;
        instr_done = 1'b0;
        if (reset) begin
            case (cur)
                S_FETCH: begin
                    if (run) begin
                        memread = 1'b1;
                        IRwrite = 1'b1;
                        pcwrite = 1'b1;
                    end
                end
                S_MEMRD: begin
                    iord    = 1'b1;
                    memread = 1'b1;
                end
                S_LDWB: begin
                    memtoacc   = 1'b1;
                    accwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXEC: begin
                    alusrc1 = 1'b1;
                    alusrc2 = (opcode != OP_NOT);
                    case (opcode)
                        OP_SUB:  alucrtl = ALU_SUB;
                        OP_AND:  alucrtl = ALU_AND;
                        OP_NOT:  alucrtl = ALU_NOT;
                        default: alucrtl = ALU_ADD;
                    endcase
                end
                S_ALUWB: begin
                    accwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_STORE: begin
                    iord       = 1'b1;
                    memwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pcsrc      = 1'b1;
                    pcwrite    = 1'b1;
                    instr_done = 1'b1;
                end
                S_JZ: begin
                    alusrc1    = 1'b1;
                    alucrtl    = ALU_PASS;
                    pcsrc      = 1'b1;
                    pcwrite    = zero;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_controller.sv
// Bench for acc_controller: directed vector table, random instruction stream against a
// per-opcode micro-step model, and an asynchronous reset landing mid-instruction.
module tb_acc_controller;

    typedef logic [17:0] vec_t;  // {state, IRwrite, memread, memwrite, pcwrite, accwrite, pcsrc, alusrc1, alusrc2, memtoacc, iord, alucrtl, instr_done}

    typedef struct {
        bit          rst_n;
        bit          run;
        logic [15:0] inst;
        bit          zero;
        vec_t        exp;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset, run, zero;
    logic [15:0] inst;
    logic        IRwrite, memread, memwrite, pcwrite, accwrite, pcsrc;
    logic        alusrc1, alusrc2, memtoacc, iord, instr_done;
    logic [2:0]  alucrtl;
    logic [3:0]  state;
    vec_t        got;

    int checks = 0;
    int errors = 0;
    rec_t tbl[$];

    acc_controller dut (
        .clk(clk), .reset(reset), .run(run), .inst(inst), .zero(zero),
        .IRwrite(IRwrite), .memread(memread), .memwrite(memwrite), .pcwrite(pcwrite),
        .accwrite(accwrite), .pcsrc(pcsrc), .alusrc1(alusrc1), .alusrc2(alusrc2),
        .memtoacc(memtoacc), .iord(iord), .alucrtl(alucrtl), .state(state),
        .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    assign got = {state, IRwrite, memread, memwrite, pcwrite, accwrite, pcsrc,
                  alusrc1, alusrc2, memtoacc, iord, alucrtl, instr_done};

    function automatic vec_t mk(input logic [3:0] st, input bit irw, mr, mw, pw, aw, ps,
                                input bit a1, a2, m2a, io, input logic [2:0] alu, input bit done);
        return {st, irw, mr, mw, pw, aw, ps, a1, a2, m2a, io, alu, done};
    endfunction

    // Micro-step list per opcode: which state the instruction is in at each cycle from FETCH.
    function automatic int step_sid(input logic [2:0] op, input int pos);
        int s[$];
        case (op)
            3'd0:             s = '{0, 1, 2, 3};
            3'd2, 3'd3, 3'd4: s = '{0, 1, 2, 4, 5};
            3'd5:             s = '{0, 1, 4, 5};
            3'd1:             s = '{0, 1, 6};
            3'd6:             s = '{0, 1, 7};
            default:          s = '{0, 1, 8};
        endcase
        return (pos < s.size()) ? s[pos] : -1;
    endfunction

    function automatic vec_t exp_of(input int sid, input logic [2:0] op, input bit z);
        logic [2:0] alu;
        alu = (op == 3'd3) ? 3'b001 : (op == 3'd4) ? 3'b010 : (op == 3'd5) ? 3'b011 : 3'b000;
        case (sid)
            0:       return mk(4'd0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
            1:       return mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
            2:       return mk(4'd2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0);
            3:       return mk(4'd3, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3'b000, 1);
            4:       return mk(4'd4, 0, 0, 0, 0, 0, 0, 1, op != 3'd5, 0, 0, alu, 0);
            5:       return mk(4'd5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 1);
            6:       return mk(4'd6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 1);
            7:       return mk(4'd7, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 3'b000, 1);
            default: return mk(4'd8, 0, 0, 0, z, 0, 1, 1, 0, 0, 0, 3'b100, 1);
        endcase
    endfunction

    task automatic check(input string name, input int idx, input vec_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %05h (state %0d) expected %05h (state %0d)",
                     name, idx, got, got[17:14], exp, exp[17:14]);
        end
    endtask

    task automatic add(input bit r, input bit rn, input logic [15:0] in, input bit z, input vec_t e);
        rec_t x;
        x.rst_n = r; x.run = rn; x.inst = in; x.zero = z; x.exp = e;
        tbl.push_back(x);
    endtask

    initial begin
        vec_t vF, vD, vM, vL, vW, vS, vJ, v0;
        int pos;
        logic [2:0] op;
        bit r, rn, z;

        v0 = '0;
        vF = mk(4'd0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        vD = mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        vM = mk(4'd2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0);
        vL = mk(4'd3, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3'b000, 1);
        vW = mk(4'd5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 1);
        vS = mk(4'd6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 1);
        vJ = mk(4'd7, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 3'b000, 1);

        // Reset held with run high: everything low.
        repeat (3) add(0, 1, 16'h0005, 0, v0);
        // LDA then ADD.
        add(1, 1, 16'h0005, 0, vF); add(1, 1, 16'h0005, 0, vD);
        add(1, 1, 16'h0005, 0, vM); add(1, 1, 16'h0005, 0, vL);
        add(1, 1, 16'h4006, 0, vF); add(1, 1, 16'h4006, 0, vD); add(1, 1, 16'h4006, 0, vM);
        add(1, 1, 16'h4006, 0, mk(4'd4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b000, 0));
        add(1, 1, 16'h4006, 0, vW);
        // STA.
        add(1, 1, 16'h2010, 0, vF); add(1, 1, 16'h2010, 0, vD); add(1, 1, 16'h2010, 0, vS);
        // JZ taken and not taken.
        add(1, 1, 16'hE020, 1, vF); add(1, 1, 16'hE020, 1, vD);
        add(1, 1, 16'hE020, 1, mk(4'd8, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 3'b100, 1));
        add(1, 1, 16'hE020, 0, vF); add(1, 1, 16'hE020, 0, vD);
        add(1, 1, 16'hE020, 0, mk(4'd8, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3'b100, 1));
        // SUB with run dropped during EXEC: finishes, parks, restarts when run returns.
        add(1, 1, 16'h6003, 0, vF); add(1, 1, 16'h6003, 0, vD); add(1, 1, 16'h6003, 0, vM);
        add(1, 0, 16'h6003, 0, mk(4'd4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b001, 0));
        add(1, 0, 16'h6003, 0, vW);
        add(1, 0, 16'h6003, 0, v0); add(1, 0, 16'h6003, 1, v0);
        add(1, 1, 16'h6003, 0, vF); add(1, 1, 16'h6003, 0, vD); add(1, 1, 16'h6003, 0, vM);
        add(1, 1, 16'h6003, 0, mk(4'd4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b001, 0));
        add(1, 1, 16'h6003, 0, vW);
        // NOT, JMP, AND.
        add(1, 1, 16'hA000, 0, vF); add(1, 1, 16'hA000, 0, vD);
        add(1, 1, 16'hA000, 0, mk(4'd4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b011, 0));
        add(1, 1, 16'hA000, 0, vW);
        add(1, 1, 16'hC123, 0, vF); add(1, 1, 16'hC123, 0, vD); add(1, 1, 16'hC123, 0, vJ);
        add(1, 1, 16'h8001, 0, vF); add(1, 1, 16'h8001, 0, vD); add(1, 1, 16'h8001, 0, vM);
        add(1, 1, 16'h8001, 1, mk(4'd4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b010, 0));
        add(1, 1, 16'h8001, 0, vW);
        add(1, 0, 16'h8001, 0, v0);

        reset = 1'b0; run = 1'b1; inst = 16'h0005; zero = 1'b0;
        @(posedge clk); #1;
        foreach (tbl[i]) begin
            reset = tbl[i].rst_n; run = tbl[i].run; inst = tbl[i].inst; zero = tbl[i].zero;
            #2;
            check("table", i, tbl[i].exp);
            @(posedge clk); #1;
        end

        // Random instruction stream; pos is the micro-step index within the current instruction.
        pos = 0;
        op  = 3'd0;
        for (int c = 0; c < 600; c++) begin
            r  = ($urandom_range(0, 40) != 0);
            rn = ($urandom_range(0, 3) != 0);
            z  = $urandom_range(0, 1) == 1;
            if (pos == 0) begin
                inst = 16'($urandom);
                op   = inst[15:13];
            end
            reset = r; run = rn; zero = z;
            #2;
            if (!r) begin
                check("rand_reset", c, '0);
                pos = 0;
            end else if (pos == 0 && !rn) begin
                check("rand_idle", c, '0);
            end else begin
                check("rand_step", c, exp_of(step_sid(op, pos), op, z));
                pos++;
                if (step_sid(op, pos) < 0) pos = 0;
            end
            @(posedge clk); #1;
        end

        // Asynchronous reset landing in MEMRD of an LDA.
        reset = 1'b0; run = 1'b1; zero = 1'b0; inst = 16'h0005;
        #2; check("seq_pre_reset", 0, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        #2; check("seq_fetch", 0, vF);
        @(posedge clk); #1;
        #2; check("seq_decode", 0, vD);
        @(posedge clk); #1;
        #2; check("seq_memrd", 0, vM);
        reset = 1'b0;
        #1; check("rst_mid_memrd", 0, '0);
        @(posedge clk); #1;
        check("rst_hold", 0, '0);
        reset = 1'b1; run = 1'b0;
        #2; check("rst_release_idle", 0, '0);
        run = 1'b1;
        #1; check("run_rise_fetch", 0, vF);
        @(posedge clk); #1;
        #2; check("run_rise_decode", 0, vD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_controller.md
# acc_controller

Multicycle FSM controller that sequences the 16-bit accumulator datapath: program counter, instruction register, memory, MDR, ALU/ALUout, and accumulator. It fetches each instruction, decodes opcode `inst[15:13]`, and drives every datapath control line one state per cycle. It pairs one-to-one with the datapath, taking `inst` and `zero` from it, and adds a `run` gate for start/pause.

## Interface
- No parameters; all widths fixed by the datapath.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low. 0 resets the controller.
- `run` input 1: 1 lets the controller leave FETCH; 0 holds it in FETCH with all enables low.
- `inst` input 16: IR contents. `[15:13]` is the opcode, `[12:0]` the address (used by the datapath).
- `zero` input 1: ALU zero flag, combinational from the current ALU operation.
- `IRwrite`, `memread`, `memwrite`, `pcwrite`, `accwrite` output 1: datapath write/read enables.
- `pcsrc` output 1: 0 selects PC+1 (ALU result), 1 selects IR address.
- `alusrc1` output 1: 0 selects PC, 1 selects A.
- `alusrc2` output 1: 0 selects constant 1, 1 selects MDR.
- `memtoacc` output 1: 0 selects ALUout, 1 selects MDR.
- `iord` output 1: 0 selects PC address, 1 selects IR address.
- `alucrtl` output 3: ALU operation. 000 ADD, 001 SUB (in1−in2), 010 AND, 011 NOT in1, 100 PASS in1.
- `state` output 4: current state encoding, for debug.
- `instr_done` output 1: high on the last cycle of each instruction.

## Operation
- **Opcodes:** 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 AND, 101 NOT, 110 JMP, 111 JZ. No illegal opcodes.
- **State encodings:** FETCH=0, DECODE=1, MEMRD=2, LDWB=3, EXEC=4, ALUWB=5, STORE=6, JUMP=7, JZ=8. Encodings 9–15 go to FETCH on the next edge and drive all outputs low.
- **Output defaults:** outputs are Moore decodes of `state`, except where listed. Every signal not listed for a state is 0, and `alucrtl` defaults to 000.
- **FETCH**
  - If `run`=1: `memread`=1, `iord`=0, `IRwrite`=1, `alusrc1`=0, `alusrc2`=0, `alucrtl`=ADD, `pcsrc`=0, `pcwrite`=1. Next state is DECODE.
  - If `run`=0: all outputs 0. Stay in FETCH.
- **DECODE:** no enables asserted. Next state by opcode:
  - LDA/ADD/SUB/AND → MEMRD
  - NOT → EXEC
  - STA → STORE
  - JMP → JUMP
  - JZ → JZ
- **MEMRD:** `iord`=1, `memread`=1; MDR captures at the edge. Next state is LDWB for LDA, otherwise EXEC.
- **LDWB:** `memtoacc`=1, `accwrite`=1, `instr_done`=1. Next state is FETCH.
- **EXEC:** `alusrc1`=1. `alusrc2`=1 for ADD/SUB/AND, 0 for NOT. `alucrtl` is ADD/SUB/AND/NOT per opcode. ALUout captures. Next state is ALUWB.
- **ALUWB:** `memtoacc`=0, `accwrite`=1, `instr_done`=1. Next state is FETCH.
- **STORE:** `iord`=1, `memwrite`=1, `instr_done`=1. Next state is FETCH.
- **JUMP:** `pcsrc`=1, `pcwrite`=1, `instr_done`=1. Next state is FETCH.
- **JZ:** `alusrc1`=1, `alucrtl`=PASS, `pcsrc`=1, `pcwrite`=`zero` (combinational, Mealy), `instr_done`=1. Next state is FETCH.
- **Opcode sampling:** the opcode is decoded from `inst` in DECODE, MEMRD and EXEC. IR is not rewritten outside FETCH, so `inst` is stable across the whole instruction.

## Timing
- **Reset:** while `reset`=0, the state is FETCH and every output is forced to 0 regardless of `run`. The first fetch occurs on the first rising edge after `reset` rises with `run`=1.
- **Latency, in cycles from FETCH through the cycle with `instr_done`:**
  - LDA 4
  - ADD/SUB/AND 5
  - NOT 4
  - STA 3
  - JMP 3
  - JZ 3
- **A-register lag:** A copies ACC one cycle late. Every instruction spends at least one FETCH cycle after an `accwrite`, so A is valid by the next EXEC, STORE or JZ. No stall is needed.
- **`run` handshake:**
  - `run` is sampled only in FETCH. Dropping `run` mid-instruction does not stop that instruction; the controller parks in the next FETCH.
  - Raising `run` in FETCH starts the fetch in that same cycle, because the outputs are combinational on `run`.
- **Reset mid-instruction:** the state goes to FETCH immediately and any write enable drops in the same cycle (asynchronous). Datapath contents are not touched by the controller.
- **`pcwrite` during JZ:** follows `zero` combinationally; `zero` must be settled before the edge.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `run`=1 → all outputs 0 and `state`=0; after release, `IRwrite`=`pcwrite`=`memread`=1 in the first cycle.
- **LDA then ADD:** `inst`=16'h0005 then 16'h4006, `run`=1 → state sequence 0,1,2,3 then 0,1,2,4,5. `memtoacc`=1 only in LDWB. In EXEC `alucrtl`=000 and `alusrc1`=`alusrc2`=1. `instr_done` pulses at cycles 4 and 9.
- **STA:** `inst`=16'h2010 → sequence 0,1,6. `memwrite`=1 and `iord`=1 only in state 6.
- **JZ:** `inst`=16'hE020. With `zero`=1 → `pcwrite`=1, `pcsrc`=1, `alucrtl`=100 in state 8. With `zero`=0 → `pcwrite`=0.
- **`run` and reset mid-instruction:** `run` drops during EXEC of SUB (16'h6003) → ALUWB completes, then stays in FETCH with all outputs 0 until `run`=1. Asserting `reset`=0 in MEMRD → `memread` drops immediately and `state`=0.
- **NOT and JMP:** `inst`=16'hA000 → EXEC with `alusrc2`=0 and `alucrtl`=011. `inst`=16'hC123 → JUMP with `pcsrc`=`pcwrite`=1.
